// File: rtl/sbox_sub_engine.sv
// AES SubBytes / InvSubBytes engine: substitutes LANES bytes of a 128-bit state per cycle
// with valid/ready handshakes on both sides and the mode frozen per block.
module sbox_sub_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int STEPS = 16 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sbox_sub_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2} state_t;

    state_t       state_r;
    logic [CW-1:0] step_r;
    logic [127:0] data_r;
    logic         mode_r;
    logic         out_valid_r;
    logic         in_ready_r;
    logic         busy_r;

    logic [3:0]   lane_idx_s  [LANES];
    logic [6:0]   lane_base_s [LANES];
    logic [7:0]   lane_in_s   [LANES];
    logic [7:0]   lane_out_s  [LANES];
    logic [127:0] data_sub_s;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, a);
            else      r = r;
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    // Per-lane byte selection and table lookup for the current step.
    always_comb begin
        data_sub_s = data_r;
        for (int l = 0; l < LANES; l++) begin
            lane_idx_s[l]  = 4'(step_r) * 4'(LANES) + 4'(l);
            lane_base_s[l] = 7'd127 - {lane_idx_s[l], 3'b000};
            lane_in_s[l]   = data_r[lane_base_s[l] -: 8];
            if (mode_r) lane_out_s[l] = sbox_inv(lane_in_s[l]);
            else        lane_out_s[l] = sbox_fwd(lane_in_s[l]);
            data_sub_s[lane_base_s[l] -: 8] = lane_out_s[l];
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            step_r      <= '0;
            data_r      <= 128'd0;
            mode_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_data;
                        mode_r     <= in_inv;
                        step_r     <= '0;
                        state_r    <= SUB;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SUB: begin
                    data_r <= data_sub_s;
                    if (step_r == CW'(STEPS - 1)) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        step_r <= step_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        step_r      <= '0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    step_r      <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = data_r;
    assign busy      = busy_r;

endmodule

// File: doc/sbox_sub_engine.md
Name: sbox_sub_engine

Overview:
Multi-lane, mode-selectable AES byte-substitution engine for a 128-bit state. It applies SubBytes (forward) or InvSubBytes (inverse) per FIPS-197, processing LANES bytes per clock with valid/ready handshakes on both sides. It sits between the round-key XOR and ShiftRows stages of the iterative AES-128 datapath and serves both the encrypt and decrypt paths.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (must divide 16; any other value is a elaboration error)
STEPS, 16/LANES, derived (localparam), substitution cycles per block
CW, clog2(STEPS) min 1, derived (localparam), step counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream block valid
in_ready  output  1  engine can accept a block
in_data  input  128  state; byte i = in_data[127-8i -: 8], byte 0 = MSB byte
in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled at accept
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  128  substituted state, same byte ordering
busy  output  1  high in SUB or DONE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low (rst_n). Assertion clears everything immediately regardless of clock.
- Reset values: state=IDLE, step=0, data register=0, mode=0, out_valid=0, out_data=0, busy=0, in_ready=1 after reset release.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_data into the working register, latch in_inv into mode, clear step, and go to SUB.
  - SUB: each cycle, bytes step*LANES .. step*LANES+LANES-1 of the working register are replaced in place by the S-box (mode) of their current value. Step increments. At step==STEPS-1, the final lanes are written and the FSM goes to DONE.
  - DONE: out_valid=1, out_data=working register. The data is held stable while out_ready=0. On out_ready, go to IDLE.
- in_ready = (state==IDLE) only. No accept occurs in SUB or DONE. in_data and in_inv are ignored outside IDLE.
- Latency: accept in cycle T gives out_valid in cycle T+STEPS+1 (LANES=16 → T+2; LANES=1 → T+17).
- Minimum initiation interval: STEPS+2 cycles with out_ready held high.
- Bytes not yet processed keep their input value. No byte is substituted twice.
- The mode is frozen for the whole block, even if in_inv toggles.
- out_valid must not drop before the handshake completes. out_data changes only on a new accept and the subsequent SUB cycles, while out_valid is low.
- Each lane uses combinational forward and inverse 256-entry tables (FIPS-197), muxed by mode. There is one table pair per lane and no table sharing across cycles.
- Reset mid-SUB or mid-DONE aborts the block. No out_valid is generated for it.
- If out_ready=1 already on DONE entry, the handshake completes in that cycle and the FSM is back in IDLE next cycle.

Test Plan:
1. Forward, LANES=4: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0 → out_data=d42711aee0bf98f1b8b45de51e415230, out_valid exactly 5 cycles after the accept.
2. Inverse round trip: feed d42711aee0bf98f1b8b45de51e415230 with in_inv=1 → 193de3bea0f4e22b9ac68d2ae9f84808. All-zero input with inv=1 → all bytes 52; with inv=0 → all bytes 63.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and out_data stable, in_ready=0 throughout, in_valid pulses ignored. Release → IDLE next cycle.
4. Mode freeze: accept with in_inv=0, then toggle in_inv every cycle during SUB → result equals the pure forward result (case 1).
5. Reset mid-operation: assert rst_n=0 asynchronously at step 2 → out_valid=0, in_ready=1 after release. The next block 00..00 (fwd) → 6363...63 with correct latency.
6. Parameter sweep LANES=1,2,8,16 with the case-1 vector → identical out_data. Latencies are 17, 9, 3 and 2 cycles respectively.
